// File: rtl/load_store_unit_if.sv
// Word-addressed memory bus between the load/store unit (master) and the memory side (slave).
interface load_store_unit_if;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = DW / 8;

  logic           bus_req;
  logic           bus_we;
  logic [AW-1:0]  bus_addr;
  logic [BEW-1:0] bus_be;
  logic [DW-1:0]  bus_wdata;
  logic [DW-1:0]  bus_rdata;
  logic           bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access on a word bus with lane steering, load extension
// and an ack timeout. Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       ld_data,
  output logic              ld_valid,
  output logic              err,
  load_store_unit_if.master bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned BEW   = XLEN / 8;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       lane_q, lane_d;
  logic             is_load_q, is_load_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [XLEN-1:0]  bus_addr_q, bus_addr_d;
  logic [BEW-1:0]   bus_be_q, bus_be_d;
  logic [XLEN-1:0]  bus_wdata_q, bus_wdata_d;
  logic [XLEN-1:0]  ld_data_q, ld_data_d;
  logic             ld_valid_q, ld_valid_d;
  logic             err_q, err_d;

  logic             start_c;
  logic             is_byte_c;
  logic             is_half_c;
  logic             misalign_c;
  logic             timeout_c;
  logic [1:0]       lane_c;
  logic [BEW-1:0]   be_c;
  logic [XLEN-1:0]  wdata_c;
  logic [7:0]       rd_byte_c;
  logic [15:0]      rd_half_c;
  logic [XLEN-1:0]  load_c;

  assign start_c   = ex_valid && (mem_rd || mem_wr);
  assign is_byte_c = (funct3[1:0] == 2'b00);
  assign is_half_c = (funct3[1:0] == 2'b01);
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Address bits finer than the access size never select a lane.
  assign lane_c = is_byte_c ? addr[1:0] : (is_half_c ? {addr[1], 1'b0} : 2'b00);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_c = (is_half_c && addr[0]) ||
                      (!is_byte_c && !is_half_c && (addr[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  // Store lane steering: byte enables plus replicated write data.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata;
    if (is_byte_c) begin
      be_c    = 4'b0001 << lane_c;
      wdata_c = {4{wdata[7:0]}};
    end else if (is_half_c) begin
      be_c    = 4'b0011 << lane_c;
      wdata_c = {2{wdata[15:0]}};
    end
  end

  // Load lane select and sign/zero extension from the captured size and lane.
  always_comb begin
    rd_byte_c = bus.bus_rdata[7:0];
    case (lane_q)
      2'd1:    rd_byte_c = bus.bus_rdata[15:8];
      2'd2:    rd_byte_c = bus.bus_rdata[23:16];
      2'd3:    rd_byte_c = bus.bus_rdata[31:24];
      default: rd_byte_c = bus.bus_rdata[7:0];
    endcase
    rd_half_c = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   load_c = {{24{rd_byte_c[7] & ~funct3_q[2]}}, rd_byte_c};
      2'b01:   load_c = {{16{rd_half_c[15] & ~funct3_q[2]}}, rd_half_c};
      default: load_c = bus.bus_rdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    is_load_d   = is_load_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    ld_data_d   = ld_data_q;
    ld_valid_d  = 1'b0;
    err_d       = 1'b0;
    stall       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          stall     = 1'b1;
          funct3_d  = funct3;
          lane_d    = lane_c;
          is_load_d = mem_rd;
          if (misalign_c) begin
            // DONE keeps stall low for one cycle so the trapped instruction retires.
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = !mem_rd;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_be_d    = be_c;
            bus_wdata_d = wdata_c;
            cnt_d       = '0;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        if (bus.bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = ST_DONE;
          if (is_load_q) begin
            ld_data_d  = load_c;
            ld_valid_d = 1'b1;
          end
        end else if (timeout_c) begin
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
      is_load_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      ld_data_q   <= '0;
      ld_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      is_load_q   <= is_load_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      ld_data_q   <= ld_data_d;
      ld_valid_q  <= ld_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign ld_data       = ld_data_q;
  assign ld_valid      = ld_valid_q;
  assign err           = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a transaction-level model predicts every cycle's
// outputs; a few literal scenarios pin that model to hand-worked values.
module tb_load_store_unit;
  localparam int unsigned TMO = 4;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        mem_rd;
  logic        mem_wr;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        err;

  load_store_unit_if bus_if();

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ex_valid (ex_valid),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .stall    (stall),
    .ld_data  (ld_data),
    .ld_valid (ld_valid),
    .err      (err),
    .bus      (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic        e_stall, e_req, e_ldv, e_err, e_bus, e_we, e_wchk, e_ldd;
  logic [31:0] e_addr, e_wdata, e_ld_data;
  logic [3:0]  e_be;

  int          obs_stall = 0, obs_req = 0, obs_ldv = 0, obs_err = 0;
  int          ldv_cyc = 0, start_cyc = 0;
  logic [31:0] last_addr, last_wdata, last_ld;
  logic [3:0]  last_be;
  logic        last_we;

  logic [2:0]  ld_f3 [0:4] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  // Reference model: access size in bytes, naturally aligned byte offset within the word.
  function automatic int unsigned m_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int unsigned m_off(input logic [2:0] f3, input logic [31:0] a);
    int unsigned s = m_size(f3);
    return ((a % 4) / s) * s;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned s = m_size(f3);
    return 4'(((32'd1 << s) - 32'd1) << m_off(f3, a));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int unsigned s = m_size(f3);
    if (s == 1) return (wd & 32'h0000_00FF) * 32'h0101_0101;
    if (s == 2) return (wd & 32'h0000_FFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    int unsigned s   = m_size(f3);
    int unsigned off = m_off(f3, a);
    longint      v;
    v = longint'(rd >> (8 * off));
    if (s < 4) begin
      v = v % (longint'(1) << (8 * s));
      if (!f3[2] && v >= (longint'(1) << (8 * s - 1))) v = v - (longint'(1) << (8 * s));
    end
    return 32'(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of the DUT against the current expectation.
  task automatic compare_now();
    check("stall",    32'(stall),          32'(e_stall));
    check("bus_req",  32'(bus_if.bus_req), 32'(e_req));
    check("ld_valid", 32'(ld_valid),       32'(e_ldv));
    check("err",      32'(err),            32'(e_err));
    if (e_bus) begin
      check("bus_we",   32'(bus_if.bus_we), 32'(e_we));
      check("bus_addr", bus_if.bus_addr,    e_addr);
      check("bus_be",   32'(bus_if.bus_be), 32'(e_be));
      if (e_wchk) check("bus_wdata", bus_if.bus_wdata, e_wdata);
    end
    if (e_ldd) check("ld_data", ld_data, e_ld_data);
    if (stall) obs_stall++;
    if (err) obs_err++;
    if (bus_if.bus_req) begin
      obs_req++;
      last_addr  = bus_if.bus_addr;
      last_be    = bus_if.bus_be;
      last_wdata = bus_if.bus_wdata;
      last_we    = bus_if.bus_we;
    end
    if (ld_valid) begin
      obs_ldv++;
      last_ld = ld_data;
      ldv_cyc = cyc;
    end
  endtask

  task automatic end_cycle();
    @(negedge clk);
    compare_now();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_exp_idle();
    e_stall = 1'b0; e_req = 1'b0; e_ldv = 1'b0; e_err = 1'b0;
    e_bus = 1'b0; e_wchk = 1'b0; e_ldd = 1'b0;
  endtask

  task automatic set_exp_reset();
    set_exp_idle();
    e_bus = 1'b1; e_we = 1'b0; e_addr = '0; e_be = '0; e_wchk = 1'b1; e_wdata = '0;
    e_ldd = 1'b1; e_ld_data = '0;
  endtask

  task automatic junk_inputs(input bit allow_valid);
    ex_valid         = allow_valid ? 1'($urandom) : 1'b0;
    mem_rd           = 1'($urandom);
    mem_wr           = 1'($urandom);
    funct3           = 3'($urandom);
    addr             = $urandom;
    wdata            = $urandom;
    bus_if.bus_rdata = $urandom;
    bus_if.bus_ack   = 1'($urandom);
  endtask

  task automatic idle_cycle();
    junk_inputs(1'b0);
    set_exp_idle();
    end_cycle();
  endtask

  // One access from start cycle to DONE (or timeout abort); ack_at is the REQ-cycle index of the ack.
  task automatic run_access(input bit ld, input bit both, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                            input bit fix_rd, input logic [31:0] rd);
    logic [31:0] c_ld  = '0;
    bit          acked = 1'b0;
    start_cyc        = cyc;
    ex_valid         = 1'b1;
    mem_rd           = ld;
    mem_wr           = !ld || both;
    funct3           = f3;
    addr             = a;
    wdata            = wd;
    bus_if.bus_ack   = 1'($urandom);
    bus_if.bus_rdata = $urandom;
    set_exp_idle();
    e_stall = 1'b1;
    end_cycle();
    for (int i = 0; i < int'(TMO); i++) begin
      junk_inputs(1'b1);
      bus_if.bus_ack = (i == ack_at);
      if (fix_rd) bus_if.bus_rdata = rd;
      if (i == ack_at) c_ld = m_load(f3, a, bus_if.bus_rdata);
      set_exp_idle();
      e_stall = 1'b1; e_req = 1'b1; e_bus = 1'b1;
      e_we = !ld; e_addr = a & 32'hFFFF_FFFC; e_be = m_be(f3, a);
      e_wchk = !ld; e_wdata = m_wdata(f3, wd);
      end_cycle();
      if (i == ack_at) begin
        acked = 1'b1;
        break;
      end
    end
    junk_inputs(acked);
    set_exp_idle();
    if (acked) begin
      e_ldv = ld; e_ldd = ld; e_ld_data = c_ld;
    end else begin
      e_err = 1'b1;
    end
    end_cycle();
  endtask

  int s_stall, s_req, s_ldv, s_err;

  task automatic snap();
    s_stall = obs_stall; s_req = obs_req; s_ldv = obs_ldv; s_err = obs_err;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    junk_inputs(1'b0);
    @(posedge clk);
    #1;
    set_exp_reset();
    end_cycle();
    rst_n = 1'b1;
    junk_inputs(1'b0);
    set_exp_reset();
    end_cycle();
    idle_cycle();

    // LB with sign extension from the top lane, ack in the first REQ cycle.
    snap();
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 1'b1, 32'h80FF_FF00);
    check("lb_addr", last_addr, 32'h0000_1000);
    check("lb_be", 32'(last_be), 32'h8);
    check("lb_data", last_ld, 32'hFFFF_FF80);
    check("lb_latency", 32'(ldv_cyc - start_cyc), 32'd2);
    idle_cycle();

    // SB with byte replication, ack after three REQ cycles.
    snap();
    run_access(1'b0, 1'b0, 3'b000, 32'h0000_2002, 32'h0000_00AB, 2, 1'b0, 32'h0);
    check("sb_we", 32'(last_we), 32'd1);
    check("sb_be", 32'(last_be), 32'h4);
    check("sb_wdata", last_wdata, 32'hABAB_ABAB);
    check("sb_stall_cycles", 32'(obs_stall - s_stall), 32'd4);
    check("sb_no_ld_valid", 32'(obs_ldv - s_ldv), 32'd0);

    // LHU from the upper half.
    run_access(1'b1, 1'b0, 3'b101, 32'h0000_0006, 32'h0, 1, 1'b1, 32'h9234_5678);
    check("lhu_be", 32'(last_be), 32'hC);
    check("lhu_data", last_ld, 32'h0000_9234);

    // Timeout: no ack at all.
    snap();
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 100, 1'b0, 32'h0);
    check("tmo_req_cycles", 32'(obs_req - s_req), 32'd4);
    check("tmo_err_pulses", 32'(obs_err - s_err), 32'd1);
    check("tmo_no_ld_valid", 32'(obs_ldv - s_ldv), 32'd0);
    idle_cycle();

    // Misaligned word load and half store are issued with low bits ignored.
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0002, 32'h0, 0, 1'b1, 32'h1122_3344);
    check("lw_mis_addr", last_addr, 32'h0000_0000);
    check("lw_mis_be", 32'(last_be), 32'hF);
    check("lw_mis_data", last_ld, 32'h1122_3344);
    run_access(1'b0, 1'b0, 3'b001, 32'h0000_0013, 32'h1234_ABCD, 0, 1'b0, 32'h0);
    check("sh_mis_be", 32'(last_be), 32'hC);
    check("sh_mis_wdata", last_wdata, 32'hABCD_ABCD);

    // Reset during REQ abandons the access; a later stray ack does nothing.
    ex_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'b010;
    addr = 32'h0000_0100; wdata = 32'h0; bus_if.bus_ack = 1'b0;
    set_exp_idle(); e_stall = 1'b1;
    end_cycle();
    junk_inputs(1'b0); bus_if.bus_ack = 1'b0;
    set_exp_idle(); e_stall = 1'b1; e_req = 1'b1;
    end_cycle();
    junk_inputs(1'b0); bus_if.bus_ack = 1'b0; rst_n = 1'b0;
    set_exp_idle(); e_stall = 1'b1; e_req = 1'b1;
    end_cycle();
    rst_n = 1'b1;
    junk_inputs(1'b0); bus_if.bus_ack = 1'b0;
    set_exp_reset();
    end_cycle();
    junk_inputs(1'b0); bus_if.bus_ack = 1'b1;
    set_exp_idle();
    end_cycle();
    idle_cycle();

    // Random accesses, random ack latency (some time out), random gaps incl. back-to-back.
    for (int n = 0; n < 300; n++) begin
      bit         ld;
      bit         both;
      logic [2:0] f3;
      ld   = 1'($urandom);
      both = ld && ($urandom_range(0, 7) == 0);
      if (ld) f3 = ld_f3[$urandom_range(0, 4)];
      else    f3 = 3'($urandom_range(0, 2));
      run_access(ld, both, f3, $urandom, $urandom, int'($urandom_range(0, 5)), 1'b0, 32'h0);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, maximum cycles to wait for bus_ack before the access is aborted.
REQ-002 The block SHALL use one clock and a reset that is synchronous and active-low; ports are named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 ex_valid  input  1  the execute-stage operands this cycle are valid.
REQ-006 mem_rd / mem_wr  input  1 each  load / store request; both high is illegal and treated as load.
REQ-007 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  input  32  effective address, i.e. the execute-stage ALU output.
REQ-009 wdata  input  32  store data, i.e. forwarded rs2.
REQ-010 stall  output  1  holds the pipeline front while an access is outstanding.
REQ-011 ld_data  output  32  aligned and extended load result.
REQ-012 ld_valid  output  1  one-cycle pulse marking ld_data valid.
REQ-013 bus_req, bus_we  output  1 each  bus request and write enable.
REQ-014 bus_addr  output  32  word address with bits [1:0] equal to 0.
REQ-015 bus_be  output  4  byte enables.
REQ-016 bus_wdata  output  32  lane-replicated store data.
REQ-017 bus_rdata  input  32  read data, sampled only when bus_ack is high.
REQ-018 bus_ack  input  1  single-cycle completion strobe.
REQ-019 err  output  1  one-cycle pulse on timeout (and on misalignment, see REQ-034).

Function
REQ-020 FSM states: IDLE, REQ, DONE.
REQ-021 Start condition: in IDLE, ex_valid and (mem_rd or mem_wr) captures addr, wdata, funct3 and the access type, then moves to REQ at the next edge.
REQ-022 stall SHALL be combinational = (IDLE and start) or REQ; it is low in DONE so the pipeline advances exactly once.
REQ-023 In REQ, bus_req stays high and bus_addr/bus_we/bus_be/bus_wdata stay stable until bus_ack.
REQ-024 bus_ack is legal in the first REQ cycle; minimum latency is start to DONE in 2 edges.
REQ-025 On bus_ack in REQ: move to DONE, deassert bus_req at that edge, and latch the extended read data for loads.
REQ-026 DONE lasts one cycle: ld_valid pulses there for loads only; the next state is IDLE.
REQ-027 Byte enables: B = 0001 shifted left by addr[1:0]; H = 0011 shifted left by 2*addr[1]; W = 1111.
REQ-028 bus_wdata: byte replicated into all 4 lanes for B, half replicated into 2 lanes for H, full word for W.
REQ-029 Load extract: select the lane by addr[1:0]; sign-extend for B/H and zero-extend for BU/HU.
REQ-030 Timeout counter: cleared on entry to REQ and incremented each REQ cycle without ack. When it reaches TIMEOUT_CYCLES, the access aborts: err pulses, bus_req drops, no ld_valid, and the state returns to IDLE.
REQ-031 bus_ack in IDLE or DONE SHALL be ignored.
REQ-032 ex_valid is not sampled outside IDLE, so back-to-back accesses start no sooner than the cycle after DONE.

Reset
REQ-033 With rst_n low at an edge, the FSM goes to IDLE and the counter to 0. bus_req, bus_we, ld_valid and err go to 0; bus_be, bus_addr, bus_wdata and ld_data go to 0. A reset mid-access abandons it with no err pulse.

Configuration
REQ-034 Macro LSU_MISALIGN_TRAP_EN, when defined: an H access with addr[0]=1, or a W access with addr[1:0]!=0, raises err in the cycle after start. No bus_req is issued and the FSM returns to IDLE from a one-cycle abort path.
REQ-035 When LSU_MISALIGN_TRAP_EN is undefined: low address bits below the access size are ignored (forced to 0), the access is always issued, and err is never raised for alignment.

Verification
REQ-036 LB, addr=0x1003, bus_rdata=0x80FF_FF00, ack in first REQ cycle -> bus_addr=0x1000, bus_be=1000, ld_data=0xFFFF_FF80, ld_valid exactly 2 cycles after start.
REQ-037 SB, addr=0x2002, wdata=0x0000_00AB, ack after 3 cycles -> bus_we=1, bus_be=0100, bus_wdata=0xABAB_ABAB, stall high 4 cycles, no ld_valid.
REQ-038 LHU, addr=0x0006, bus_rdata=0x9234_5678 -> bus_be=1100, ld_data=0x0000_9234.
REQ-039 Load with TIMEOUT_CYCLES=4 and no ack -> err pulse after 4 REQ cycles, bus_req low next cycle, FSM in IDLE, no ld_valid.
REQ-040 LW, addr=0x0002, LSU_MISALIGN_TRAP_EN defined -> err pulse, bus_req never high; undefined -> bus_addr=0x0000, bus_be=1111.
REQ-041 rst_n low for one cycle during REQ -> next cycle bus_req=0, stall=0, err=0; a stray bus_ack afterwards causes no ld_valid.
